// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store data ports.
// Data has priority; a bounded burst counter keeps fetch from being starved.
module mem_arbiter #(
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  // owner     | meaning
  // OWN_NONE  | no access issued last cycle
  // OWN_I     | fetch issued last cycle, response due now
  // OWN_D     | load/store issued last cycle, response due now
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_D_BURST);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       gnt_d, gnt_i;

  // Grants are gated by reset so nothing is accepted or written while rst_i is low.
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (rst_i) begin
      if (d_req_i && (!i_req_i || (starve_q < MaxBurst))) begin
        gnt_d = 1'b1;
      end else if (i_req_i) begin
        gnt_i = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    owner_d  = OWN_NONE;
    if (!i_req_i || gnt_i) begin
      starve_d = 4'd0;
    end else if (gnt_d && (starve_q < MaxBurst)) begin
      starve_d = starve_q + 4'd1;
    end
    if (gnt_d) begin
      owner_d = OWN_D;
    end else if (gnt_i) begin
      owner_d = OWN_I;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign i_gnt_o    = gnt_i;
  assign d_gnt_o    = gnt_d;
  assign mem_wen_o  = gnt_d & d_we_i;
  assign mem_addr_o = gnt_d ? d_addr_i : i_addr_i;
  assign mem_data_o = d_wdata_i;

  assign i_rvalid_o = (owner_q == OWN_I);
  assign d_rvalid_o = (owner_q == OWN_D);
  assign i_rdata_o  = mem_data_i;
  assign d_rdata_o  = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single-cycle behaviour plus
// hand sequences for the starvation guard and reset corner cases.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_wen;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_data, mem_rdata;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_D_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_data_i(mem_rdata)
  );

  // Synchronous memory; write lands before any later read of the same word.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_wen) mem[mem_addr[9:2]] <= mem_data;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_wen;
    logic [31:0] e_addr;
    logic        e_irv;
    logic        e_drv;
    logic        c_ird;
    logic [31:0] e_ird;
    logic        c_drd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dw);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
  endtask

  task automatic chk_quiet(input string nm, input logic e_irv, input logic e_drv);
    chk({nm, "_igt"}, 32'(i_gnt), 32'd0);
    chk({nm, "_dgt"}, 32'(d_gnt), 32'd0);
    chk({nm, "_wen"}, 32'(mem_wen), 32'd0);
    chk({nm, "_irv"}, 32'(i_rvalid), 32'(e_irv));
    chk({nm, "_drv"}, 32'(d_rvalid), 32'(e_drv));
  endtask

  logic exp_i, prev_i;

  initial begin
    //        ireq iaddr   dreq dwe daddr   dwdata        igt dgt wen addr    irv drv cird ird    cdrd drd
    vecs[0]  = '{0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0, 32'h0};
    vecs[1]  = '{1, 32'h0, 0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0, 32'h0};
    vecs[2]  = '{1, 32'h4, 0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h4,  1, 0, 1, 32'h11, 0, 32'h0};
    vecs[3]  = '{1, 32'h8, 0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h8,  1, 0, 1, 32'h22, 0, 32'h0};
    vecs[4]  = '{0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  1, 0, 1, 32'h33, 0, 32'h0};
    vecs[5]  = '{0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 1, 32'h40, 0, 0, 0, 32'h0,  0, 32'h0};
    vecs[6]  = '{0, 32'h0, 1, 0, 32'h40, 32'h0,        0, 1, 0, 32'h40, 0, 1, 0, 32'h0,  0, 32'h0};
    vecs[7]  = '{0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  0, 1, 0, 32'h0,  1, 32'hDEADBEEF};
    vecs[8]  = '{1, 32'h4, 1, 0, 32'h8,  32'h0,        0, 1, 0, 32'h8,  0, 0, 0, 32'h0,  0, 32'h0};
    vecs[9]  = '{1, 32'h4, 0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h4,  0, 1, 0, 32'h0,  1, 32'h33};
    vecs[10] = '{0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  1, 0, 1, 32'h22, 0, 32'h0};
    vecs[11] = '{0, 32'h0, 1, 1, 32'h44, 32'h5A5A5A5A, 0, 1, 1, 32'h44, 0, 0, 0, 32'h0,  0, 32'h0};
    vecs[12] = '{0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  0, 1, 0, 32'h0,  0, 32'h0};

    rst_i = 1'b0;
    pre_we = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
    drive(0, 0, 0, 0, 0, 0);

    // Preload while in reset; grants must stay off even with requests present.
    for (int w = 0; w < 3; w++) begin
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = 8'(w); pre_data = 32'(w + 1) * 32'h11;
      drive(1, 32'h0, 1, 1, 32'h40, 32'h12345678);
      @(negedge clk);
      chk_quiet($sformatf("rst%0d", w), 0, 0);
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk_quiet("rel", 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk_quiet($sformatf("idle%0d", c), 0, 0);
    end

    for (int r = 0; r < 13; r++) begin
      @(posedge clk); #1;
      drive(vecs[r].i_req, vecs[r].i_addr, vecs[r].d_req, vecs[r].d_we, vecs[r].d_addr, vecs[r].d_wdata);
      @(negedge clk);
      chk($sformatf("row%0d_igt", r), 32'(i_gnt), 32'(vecs[r].e_igt));
      chk($sformatf("row%0d_dgt", r), 32'(d_gnt), 32'(vecs[r].e_dgt));
      chk($sformatf("row%0d_wen", r), 32'(mem_wen), 32'(vecs[r].e_wen));
      chk($sformatf("row%0d_addr", r), mem_addr, vecs[r].e_addr);
      chk($sformatf("row%0d_wdata", r), mem_data, vecs[r].d_wdata);
      chk($sformatf("row%0d_irv", r), 32'(i_rvalid), 32'(vecs[r].e_irv));
      chk($sformatf("row%0d_drv", r), 32'(d_rvalid), 32'(vecs[r].e_drv));
      if (vecs[r].c_ird) chk($sformatf("row%0d_ird", r), i_rdata, vecs[r].e_ird);
      if (vecs[r].c_drd) chk($sformatf("row%0d_drd", r), d_rdata, vecs[r].e_drd);
    end

    // Data alone never accumulates starvation count.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive(0, 32'h0, 1, 0, 32'h8, 32'h0);
      @(negedge clk);
      chk($sformatf("donly%0d_dgt", c), 32'(d_gnt), 32'd1);
    end

    // Both requesting: D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++) begin
      exp_i  = (k % 5 == 4);
      prev_i = (k % 5 == 0) && (k > 0);
      @(posedge clk); #1;
      drive(1, 32'h4, 1, 0, 32'h8, 32'h0);
      @(negedge clk);
      chk($sformatf("starve%0d_igt", k), 32'(i_gnt), 32'(exp_i));
      chk($sformatf("starve%0d_dgt", k), 32'(d_gnt), 32'(!exp_i));
      chk($sformatf("starve%0d_irv", k), 32'(i_rvalid), 32'(prev_i));
      chk($sformatf("starve%0d_drv", k), 32'(d_rvalid), 32'(!prev_i));
      if (prev_i) chk($sformatf("starve%0d_ird", k), i_rdata, 32'h22);
      else chk($sformatf("starve%0d_drd", k), d_rdata, 32'h33);
    end

    // Build up count, then reset with a data response in flight and a store pending.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive(1, 32'h4, 1, 0, 32'h8, 32'h0);
      @(negedge clk);
      chk($sformatf("pre_rst%0d_dgt", c), 32'(d_gnt), 32'd1);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      rst_i = 1'b0;
      drive(1, 32'h4, 1, 1, 32'h40, 32'hCAFEF00D);
      @(negedge clk);
      chk_quiet($sformatf("rstA%0d", c), 0, 0);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      rst_i = 1'b1;
      drive(1, 32'h4, 1, 0, 32'h40, 32'h0);
      @(negedge clk);
      chk($sformatf("postA%0d_dgt", k), 32'(d_gnt), 32'(k != 4));
      chk($sformatf("postA%0d_igt", k), 32'(i_gnt), 32'(k == 4));
      chk($sformatf("postA%0d_drv", k), 32'(d_rvalid), 32'(k != 0));
      if (k == 1) chk("postA_drd", d_rdata, 32'hDEADBEEF);
    end

    // Fetch granted, then reset before its response returns.
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 32'h8, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstB_igt", 32'(i_gnt), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_quiet("rstB_in", 0, 0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk_quiet("rstB_rel", 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("rstB_after", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
